// File: rtl/delay_scan_ctrl.sv
// delay_scan_ctrl: per-link input-delay calibration sequencer (sweep, score, centre of longest clean window).
// Optional SCAN_ERR_THRESH_EN adds err_thresh; a point is then good when errors <= err_thresh.
module delay_scan_ctrl #(
  parameter int NLINKS        = 12,
  parameter int DELAY_W       = 9,
  parameter int ERR_W         = 16,
  parameter int DELAY_STEP    = 8,
  parameter int DWELL_CYCLES  = 1024,
  parameter int READY_TIMEOUT = 255
) (
  input  logic                      clk160,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NLINKS-1:0]         link_mask,
  output logic                      busy,
  output logic                      done,
  output logic [NLINKS-1:0]         delay_set,
  output logic [NLINKS*DELAY_W-1:0] delay_in,
  output logic [NLINKS-1:0]         reset_counters,
  input  logic [NLINKS-1:0]         delay_ready,
  input  logic [NLINKS*ERR_W-1:0]   bit_align_errors,
`ifdef SCAN_ERR_THRESH_EN
  input  logic [ERR_W-1:0]          err_thresh,
`endif
  output logic [NLINKS*DELAY_W-1:0] best_delay,
  output logic [NLINKS-1:0]         scan_fail
);
  localparam int NPTS = ((2**DELAY_W) - 1) / DELAY_STEP + 1;
  localparam int CW   = $clog2(NPTS + 1);
  localparam int LW   = $clog2(NLINKS + 1);
  localparam int IW   = (NLINKS > 1) ? $clog2(NLINKS) : 1;
  localparam int WW   = $clog2(READY_TIMEOUT + 1);
  localparam int DW   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_NEXT, S_SET, S_WAIT_RDY, S_CLR, S_DWELL, S_SAMPLE, S_FINAL, S_FINAL_WAIT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [NLINKS-1:0]   mask_q, mask_d;
  logic [LW-1:0]       link_q, link_d;
  logic [DELAY_W-1:0]  d_q, d_d;
  logic [DELAY_W-1:0]  cur_start_q, cur_start_d, best_start_q, best_start_d;
  logic [CW-1:0]       cur_len_q, cur_len_d, best_len_q, best_len_d;
  logic [DELAY_W-1:0]  fin_q, fin_d;
  logic [WW-1:0]       wcnt_q, wcnt_d;
  logic [DW-1:0]       dw_q, dw_d;
  logic                busy_q, busy_d, done_q, done_d;

  // Per-link command bus; only the lane addressed by cmd_idx acts on it.
  logic [LW-1:0]       cmd_idx;
  logic                set_req, rc_req, fail_clr, fail_set, best_ld;
  logic [DELAY_W-1:0]  set_val, best_val;

  logic [NLINKS-1:0][ERR_W-1:0] errs;
  logic [ERR_W-1:0]    err_sel;
  logic                rdy_sel, good;
  logic                nxt_found;
  logic [LW-1:0]       nxt_link;
  logic [DELAY_W:0]    d_next;
  logic                last_pt;
  logic                close_longer;
  logic [DELAY_W-1:0]  fin_start;
  logic [CW-1:0]       fin_len;
  logic [DELAY_W:0]    span;
  logic [DELAY_W-1:0]  pick;

  assign errs    = bit_align_errors;
  assign err_sel = errs[link_q[IW-1:0]];
  assign rdy_sel = delay_ready[link_q[IW-1:0]];

`ifdef SCAN_ERR_THRESH_EN
  assign good = (err_sel <= err_thresh);
`else
  assign good = (err_sel == '0);
`endif

  // Extra top bit catches the step past the last tap instead of wrapping.
  assign d_next  = {1'b0, d_q} + (DELAY_W+1)'(DELAY_STEP);
  assign last_pt = d_next[DELAY_W];

  // Closing the open run against the best so far; strict compare keeps the earliest of equal runs.
  assign close_longer = (cur_len_q > best_len_q);
  assign fin_start    = close_longer ? cur_start_q : best_start_q;
  assign fin_len      = close_longer ? cur_len_q : best_len_q;
  assign span         = (DELAY_W+1)'(fin_len - CW'(1)) * (DELAY_W+1)'(DELAY_STEP);
  assign pick         = fin_start + DELAY_W'(span >> 1);

  always_comb begin
    nxt_found = 1'b0;
    nxt_link  = link_q;
    for (int i = NLINKS - 1; i >= 0; i--) begin
      if (mask_q[i] && (LW'(i) >= link_q)) begin
        nxt_found = 1'b1;
        nxt_link  = LW'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    link_d       = link_q;
    d_d          = d_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    fin_d        = fin_q;
    wcnt_d       = wcnt_q;
    dw_d         = dw_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cmd_idx      = link_q;
    set_req      = 1'b0;
    set_val      = d_q;
    rc_req       = 1'b0;
    fail_clr     = 1'b0;
    fail_set     = 1'b0;
    best_ld      = 1'b0;
    best_val     = fin_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = link_mask;
          link_d  = '0;
          busy_d  = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (!nxt_found) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          link_d       = nxt_link;
          cmd_idx      = nxt_link;
          fail_clr     = 1'b1;
          d_d          = '0;
          cur_start_d  = '0;
          cur_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
          state_d      = S_SET;
        end
      end
      S_SET: begin
        set_req = 1'b1;
        wcnt_d  = '0;
        state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        // The strobe cycle itself may still show the old settled flag, so ignore it.
        if ((wcnt_q != '0) && rdy_sel) begin
          state_d = S_CLR;
        end else if (wcnt_q == WW'(READY_TIMEOUT - 1)) begin
          fail_set = 1'b1;
          best_ld  = 1'b1;
          best_val = '0;
          link_d   = link_q + LW'(1);
          state_d  = S_NEXT;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      S_CLR: begin
        rc_req  = 1'b1;
        dw_d    = '0;
        state_d = S_DWELL;
      end
      S_DWELL: begin
        if (dw_q == DW'(DWELL_CYCLES - 1)) state_d = S_SAMPLE;
        else dw_d = dw_q + DW'(1);
      end
      S_SAMPLE: begin
        if (good) begin
          if (cur_len_q == '0) cur_start_d = d_q;
          cur_len_d = cur_len_q + CW'(1);
        end else begin
          if (close_longer) begin
            best_start_d = cur_start_q;
            best_len_d   = cur_len_q;
          end
          cur_len_d = '0;
        end
        if (last_pt) begin
          state_d = S_FINAL;
        end else begin
          d_d     = d_next[DELAY_W-1:0];
          state_d = S_SET;
        end
      end
      S_FINAL: begin
        set_req = 1'b1;
        wcnt_d  = '0;
        state_d = S_FINAL_WAIT;
        if (fin_len == '0) begin
          fail_set = 1'b1;
          set_val  = '0;
          fin_d    = '0;
        end else begin
          set_val = pick;
          fin_d   = pick;
        end
      end
      S_FINAL_WAIT: begin
        if ((wcnt_q != '0) && rdy_sel) begin
          best_ld  = 1'b1;
          best_val = fin_q;
          link_d   = link_q + LW'(1);
          state_d  = S_NEXT;
        end else if (wcnt_q == WW'(READY_TIMEOUT - 1)) begin
          fail_set = 1'b1;
          best_ld  = 1'b1;
          best_val = '0;
          link_d   = link_q + LW'(1);
          state_d  = S_NEXT;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      link_q       <= '0;
      d_q          <= '0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      fin_q        <= '0;
      wcnt_q       <= '0;
      dw_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      link_q       <= link_d;
      d_q          <= d_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      fin_q        <= fin_d;
      wcnt_q       <= wcnt_d;
      dw_q         <= dw_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // Per-link output registers; unaddressed lanes hold their slices.
  for (genvar i = 0; i < NLINKS; i++) begin : g_lane
    logic               sel;
    logic               set_q, set_d, rc_q, rc_d, fail_q, fail_d;
    logic [DELAY_W-1:0] din_q, din_d, best_q, best_d;

    assign sel = (cmd_idx == LW'(i));

    always_comb begin
      set_d  = sel & set_req;
      rc_d   = sel & rc_req;
      din_d  = (sel & set_req) ? set_val : din_q;
      best_d = (sel & best_ld) ? best_val : best_q;
      fail_d = fail_q;
      if (sel & fail_clr) fail_d = 1'b0;
      if (sel & fail_set) fail_d = 1'b1;
    end

    always_ff @(posedge clk160 or posedge rst) begin
      if (rst) begin
        set_q  <= 1'b0;
        rc_q   <= 1'b0;
        fail_q <= 1'b0;
        din_q  <= '0;
        best_q <= '0;
      end else begin
        set_q  <= set_d;
        rc_q   <= rc_d;
        fail_q <= fail_d;
        din_q  <= din_d;
        best_q <= best_d;
      end
    end

    assign delay_set[i]                       = set_q;
    assign reset_counters[i]                  = rc_q;
    assign scan_fail[i]                       = fail_q;
    assign delay_in[i*DELAY_W +: DELAY_W]     = din_q;
    assign best_delay[i*DELAY_W +: DELAY_W]   = best_q;
  end

endmodule

// File: tb/tb_delay_scan_ctrl.sv
// Bench for delay_scan_ctrl: emulated links (delay lines + error counters) and a window-search model.
module tb_delay_scan_ctrl;
  localparam int NL    = 12;
  localparam int DW    = 9;
  localparam int EW    = 16;
  localparam int STEP  = 8;
  localparam int DWELL = 4;
  localparam int RTO   = 255;
  localparam int NPTS  = ((1 << DW) - 1) / STEP + 1;

  logic              clk160 = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [NL-1:0]     link_mask = '0;
  logic              busy, done;
  logic [NL-1:0]     delay_set, reset_counters, scan_fail;
  logic [NL-1:0]     delay_ready = '1;
  logic [NL*DW-1:0]  delay_in, best_delay;
  logic [NL*EW-1:0]  bit_align_errors = '0;

  always #5 clk160 = ~clk160;

  delay_scan_ctrl #(
    .NLINKS(NL), .DELAY_W(DW), .ERR_W(EW), .DELAY_STEP(STEP),
    .DWELL_CYCLES(DWELL), .READY_TIMEOUT(RTO)
  ) dut (
    .clk160(clk160), .rst(rst), .start(start), .link_mask(link_mask),
    .busy(busy), .done(done), .delay_set(delay_set), .delay_in(delay_in),
    .reset_counters(reset_counters), .delay_ready(delay_ready),
    .bit_align_errors(bit_align_errors),
`ifdef SCAN_ERR_THRESH_EN
    .err_thresh('0),
`endif
    .best_delay(best_delay), .scan_fail(scan_fail)
  );

  int checks = 0, errors = 0;

  // Link scenario: up to two clean windows per link, optional stuck delay_ready
  int wlo[NL][2], whi[NL][2];
  bit stuck[NL];
  int tap[NL], ecnt[NL], rcnt[NL];

  // Model expectations
  int exp_seq[NL][NPTS+1];
  int exp_len[NL], exp_idx[NL], exp_best[NL];
  bit exp_fail[NL];
  logic [NL-1:0] tb_mask = '0;
  bit track = 1'b0;

  // Observations
  int nset[NL], last_set[NL];
  int ndone = 0, nbusy = 0, mcyc = 0;
  int t_set1 = -1, t_fail1 = -1;
  logic [NL*DW-1:0] prev_din = '0;
  logic [NL-1:0]    prev_fail = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit good_tap(input int i, input int t);
    for (int w = 0; w < 2; w++)
      if (t >= wlo[i][w] && t <= whi[i][w]) return 1'b1;
    return 1'b0;
  endfunction

  // Sweep every point, keep the first strictly-longest clean run, centre it.
  task automatic model(input int i);
    int bs, bl, rs, rl, t;
    exp_idx[i] = 0;
    if (stuck[i]) begin
      exp_len[i] = 1; exp_seq[i][0] = 0; exp_fail[i] = 1'b1; exp_best[i] = 0;
      return;
    end
    bs = 0; bl = 0; rs = 0; rl = 0;
    for (int p = 0; p < NPTS; p++) begin
      t = p * STEP;
      exp_seq[i][p] = t;
      if (good_tap(i, t)) begin
        if (rl == 0) rs = t;
        rl++;
        if (rl > bl) begin bl = rl; bs = rs; end
      end else rl = 0;
    end
    exp_fail[i]      = (bl == 0);
    exp_best[i]      = (bl == 0) ? 0 : (bs + (bl - 1) * STEP / 2) % (1 << DW);
    exp_seq[i][NPTS] = exp_best[i];
    exp_len[i]       = NPTS + 1;
  endtask

  // Link emulation: delay line settles 3 cycles after a strobe, errors accumulate at bad taps.
  always @(negedge clk160) begin
    for (int i = 0; i < NL; i++) begin
      if (rst) begin
        ecnt[i] = 0; rcnt[i] = 0; tap[i] = 0;
        delay_ready[i] = !stuck[i];
      end else begin
        if (reset_counters[i]) ecnt[i] = 0;
        else if (!good_tap(i, tap[i]) && ecnt[i] < 65535) ecnt[i]++;
        if (delay_set[i]) begin
          tap[i] = int'(delay_in[i*DW +: DW]);
          rcnt[i] = 2;
          delay_ready[i] = 1'b0;
        end else if (rcnt[i] > 0) rcnt[i]--;
        else delay_ready[i] = !stuck[i];
      end
      bit_align_errors[i*EW +: EW] = 16'(ecnt[i]);
    end
  end

  // Compare process
  always @(negedge clk160) begin
    bit held;
    mcyc++;
    if (!rst) begin
      if ((delay_set | reset_counters) != '0)
        chk("strobe_onehot", $countones(delay_set | reset_counters), 1);
      held = 1'b1;
      for (int i = 0; i < NL; i++) begin
        if (delay_set[i]) begin
          nset[i]++;
          last_set[i] = int'(delay_in[i*DW +: DW]);
          if (i == 1 && nset[i] == 1) t_set1 = mcyc;
          if (track) begin
            if (exp_idx[i] < exp_len[i])
              chk($sformatf("tap_l%0d_p%0d", i, exp_idx[i]), last_set[i], exp_seq[i][exp_idx[i]]);
            else
              chk($sformatf("set_count_l%0d", i), exp_idx[i] + 1, exp_len[i]);
            exp_idx[i]++;
          end
        end else if (delay_in[i*DW +: DW] != prev_din[i*DW +: DW]) held = 1'b0;
        if (i == 1 && scan_fail[1] && !prev_fail[1]) t_fail1 = mcyc;
      end
      chk("din_hold", int'(held), 1);
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (track)
          for (int i = 0; i < NL; i++)
            if (tb_mask[i]) begin
              chk($sformatf("best_l%0d", i), int'(best_delay[i*DW +: DW]), exp_best[i]);
              chk($sformatf("fail_l%0d", i), int'(scan_fail[i]), int'(exp_fail[i]));
              chk($sformatf("seq_end_l%0d", i), exp_idx[i], exp_len[i]);
            end
      end
    end
    prev_din  = delay_in;
    prev_fail = scan_fail;
  end

  task automatic clear_links();
    for (int i = 0; i < NL; i++) begin
      wlo[i][0] = 1; whi[i][0] = 0; wlo[i][1] = 1; whi[i][1] = 0;
      stuck[i] = 1'b0;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_set"}, int'(delay_set != '0), 0);
    chk({tag, "_rc"}, int'(reset_counters != '0), 0);
    chk({tag, "_fail"}, int'(scan_fail != '0), 0);
    chk({tag, "_din"}, int'(delay_in != '0), 0);
    chk({tag, "_best"}, int'(best_delay != '0), 0);
  endtask

  task automatic run_scan(input logic [NL-1:0] m, input string tag);
    int n;
    for (int i = 0; i < NL; i++) begin
      nset[i] = 0;
      if (m[i]) model(i);
    end
    tb_mask = m; track = 1'b1; ndone = 0; nbusy = 0;
    @(negedge clk160); link_mask = m; start = 1'b1;
    @(negedge clk160); start = 1'b0; link_mask = ~m;
    n = 0;
    while (ndone == 0 && n < 20000) begin @(negedge clk160); n++; end
    repeat (3) @(negedge clk160);
    chk({tag, "_done_pulses"}, ndone, 1);
    chk({tag, "_busy_after"}, int'(busy), 0);
    track = 1'b0;
  endtask

  initial begin
    int n;
    clear_links();
    for (int i = 0; i < NL; i++) begin nset[i] = 0; last_set[i] = -1; end
    #2 rst = 1'b1;
    repeat (2) @(negedge clk160);
    check_reset("por");
    rst = 1'b0;
    @(negedge clk160);

    // 1: single clean window 96..200
    wlo[0][0] = 96; whi[0][0] = 200;
    run_scan(12'h001, "t1");
    chk("t1_best_lit", int'(best_delay[0 +: DW]), 148);
    chk("t1_fail_lit", int'(scan_fail[0]), 0);
    chk("t1_sets_lit", nset[0], 65);

    // 2: two windows, the earlier one wins
    clear_links();
    wlo[0][0] = 16; whi[0][0] = 48; wlo[0][1] = 300; whi[0][1] = 332;
    run_scan(12'h001, "t2");
    chk("t2_best_lit", int'(best_delay[0 +: DW]), 32);

    // 3: link 2 never clean
    clear_links();
    run_scan(12'h004, "t3");
    chk("t3_fail_lit", int'(scan_fail[2]), 1);
    chk("t3_best_lit", int'(best_delay[2*DW +: DW]), 0);
    chk("t3_final_tap_lit", last_set[2], 0);
    chk("t3_sets_lit", nset[2], 65);

    // 4: link 1 ready stuck low, link 3 normal
    clear_links();
    stuck[1] = 1'b1; wlo[3][0] = 96; whi[3][0] = 200;
    t_set1 = -1; t_fail1 = -1;
    run_scan(12'h00A, "t4");
    chk("t4_fail1_lit", int'(scan_fail[1]), 1);
    chk("t4_best1_lit", int'(best_delay[1*DW +: DW]), 0);
    chk("t4_sets1_lit", nset[1], 1);
    chk("t4_timeout_cycles", t_fail1 - t_set1, 255);
    chk("t4_best3_lit", int'(best_delay[3*DW +: DW]), 148);
    chk("t4_fail3_lit", int'(scan_fail[3]), 0);

    // 5: clean window touching the top tap
    clear_links();
    wlo[0][0] = 480; whi[0][0] = 511;
    run_scan(12'h001, "t5");
    chk("t5_best_lit", int'(best_delay[0 +: DW]), 492);

    // 6: empty mask
    clear_links();
    run_scan(12'h000, "t6");
    chk("t6_busy_cycles", nbusy, 2);

    // 7: start while busy is ignored, then reset mid-dwell
    clear_links();
    wlo[0][0] = 96; whi[0][0] = 200;
    for (int i = 0; i < NL; i++) nset[i] = 0;
    model(0);
    tb_mask = 12'h001; track = 1'b1; ndone = 0;
    @(negedge clk160); link_mask = 12'h001; start = 1'b1;
    @(negedge clk160); start = 1'b0;
    n = 0;
    while (nset[0] < 3 && n < 2000) begin @(negedge clk160); n++; end
    chk("t7_reach_pt3", int'(nset[0] >= 3), 1);
    link_mask = 12'hFFF; start = 1'b1;
    @(negedge clk160); start = 1'b0;
    chk("t7_busy_held", int'(busy), 1);
    n = 0;
    while (reset_counters[0] !== 1'b1 && n < 2000) begin @(negedge clk160); n++; end
    chk("t7_reach_dwell", int'(reset_counters[0]), 1);
    @(negedge clk160);
    track = 1'b0;
    rst = 1'b1;
    #1;
    check_reset("t7_rst");
    @(negedge clk160);
    @(negedge clk160);
    rst = 1'b0;
    for (int i = 0; i < NL; i++) nset[i] = 0;
    nbusy = 0; ndone = 0;
    repeat (50) @(negedge clk160);
    chk("t7_no_busy", nbusy, 0);
    chk("t7_no_done", ndone, 0);
    chk("t7_no_sets", nset[0] + nset[1] + nset[2], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
